car_link_responder: RTL and testbench
=====================================

Name: car_link_responder

Overview:
- Far end of the car UART link. Sits on the simulator side behind a byte-level UART receiver and transmitter.
- Decodes command bytes of the form {2'b10, destroy_barrier, place_barrier, turn_right, turn_left, move_backward, move_forward} into registered actuator commands.
- Answers with a detector status byte {4'b0000, back, right, left, front}. Replies are sent after every accepted command and periodically when the link is idle.
- A link watchdog forces all commands to zero (safe stop) when no valid command arrives for a configured time.

Parameters:
TIMEOUT_CYCLES, 50000000, idle cycles without a valid command before safe stop (0.5 s at 100 MHz)
REPLY_PERIOD, 1000000, idle cycles between unsolicited status replies (10 ms at 100 MHz)
CNT_W, 26, width of the timeout and period counters; must hold both parameter values

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  byte from the UART receiver
rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle
tx_busy  in  1  UART transmitter busy flag
front_in, left_in, right_in, back_in  in  1 each  detector levels to report
tx_data  out  8  reply byte, held stable from tx_start until tx_busy falls
tx_start  out  1  one-cycle transmit request
move_forward, move_backward, turn_left, turn_right, place_barrier, destroy_barrier  out  1 each  decoded commands
cmd_valid  out  1  one-cycle pulse on each accepted command
frame_err  out  1  one-cycle pulse on each rejected byte
err_count  out  8  saturating count of rejected bytes
link_lost  out  1  high while the watchdog has expired

Behaviour:
- Reset (asynchronous, rst_n low): all outputs 0; counters 0; FSM in IDLE; reply-pending flag 0. link_lost is 0 out of reset; the watchdog starts counting from reset release.
- Decode, on a cycle with rx_valid=1:
  - rx_data[7:6]==2'b10 and not (bit0 & bit1): accept.
  - Accept means: command outputs take rx_data[5:0] on the next edge; cmd_valid pulses 1 cycle on that same edge; watchdog counter clears; link_lost clears; reply-pending sets.
  - Any other byte (bad header, or forward and backward both set): reject. frame_err pulses 1 cycle; err_count increments and saturates at 255; command outputs unchanged; no reply queued.
- Watchdog: counter increments every cycle without an accepted command. When it reaches TIMEOUT_CYCLES-1:
  - all six command outputs clear;
  - link_lost sets;
  - the counter holds until the next accept.
- Periodic reply: the period counter increments every cycle and clears on any accept. When it reaches REPLY_PERIOD-1 it sets reply-pending and wraps to 0.
- Reply-pending is a single flag. Multiple requests before service coalesce into one reply.
- Transmit FSM:
  - IDLE: if reply-pending and tx_busy==0, then tx_data <= {4'b0000, back_in, right_in, left_in, front_in} (sensors sampled in this cycle), tx_start=1 for 1 cycle, clear reply-pending, go to WAIT_HI.
  - WAIT_HI: wait for tx_busy==1, then go to WAIT_LO. If tx_busy is still 0 after 16 cycles, return to IDLE; tx_data keeps its value.
  - WAIT_LO: wait for tx_busy==0, then return to IDLE.
  - Earliest next tx_start is 1 cycle after tx_busy falls.
- Simultaneous events:
  - Accept and periodic wrap in the same cycle: exactly one pending reply.
  - Accept in the same cycle the FSM issues tx_start: pending clears from the current request and is set again by the accept, so one further reply follows.
  - Accept in the cycle the watchdog expires: the accept wins; commands take the new byte and link_lost stays 0.
- Reset mid-transmission: tx_start and tx_data go to 0 immediately. The external UART frame in progress is not this block's concern.
- Sensor inputs are used as levels; the integrator synchronises them upstream.

Test Plan:
- Reset, then rx_data=8'hA1 (10_100001) with rx_valid → next edge: destroy_barrier=1, move_forward=1, cmd_valid pulse; with front_in=1, left_in=1 and tx_busy idle, tx_start fires with tx_data=8'h03.
- rx_data=8'h41 (bad header), then 8'h83 (forward+backward) → two frame_err pulses, err_count=2, command outputs unchanged, no tx_start.
- TIMEOUT_CYCLES=100, REPLY_PERIOD=1000: accept 8'h81, then idle → at cycle 100 after the accept all commands are 0 and link_lost=1; a new 8'h84 clears link_lost and sets turn_left=1.
- REPLY_PERIOD=50, no rx, tx_busy modelled as 10 cycles high after each start → tx_start every 50 cycles; back_in=1, right_in=1 gives tx_data=8'h0C.
- Hold tx_busy=1 for 200 cycles while three commands are accepted → exactly one tx_start, issued 1 cycle after tx_busy falls.
- Hold tx_busy=0 permanently after a tx_start → FSM returns to IDLE after 16 cycles; a later pending reply still issues tx_start.
- Send 300 bad bytes → err_count saturates at 255.

Source files
------------

// File: rtl/car_link_responder.sv
// car_link_responder: far end of the car UART link.
// Decodes command bytes into registered actuator commands, answers with a
// detector status byte after each accepted command and periodically while
// idle, and forces a safe stop when the link goes quiet for too long.
module car_link_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned REPLY_PERIOD   = 1000000,
  parameter int unsigned CNT_W          = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tx_busy,
  input  logic       front_in,
  input  logic       left_in,
  input  logic       right_in,
  input  logic       back_in,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       move_forward,
  output logic       move_backward,
  output logic       turn_left,
  output logic       turn_right,
  output logic       place_barrier,
  output logic       destroy_barrier,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic [7:0] err_count,
  output logic       link_lost
);

  localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPLY_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       HI_LAST  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_HI = 2'd1,
    ST_WAIT_LO = 2'd2
  } tx_state_t;

  logic [5:0]       r_cmd;
  logic             r_cmd_valid;
  logic             r_frame_err;
  logic [7:0]       r_err_count;
  logic             r_link_lost;
  logic [CNT_W-1:0] r_wd_cnt;
  logic [CNT_W-1:0] r_per_cnt;
  logic             r_pending;
  tx_state_t        r_state;
  tx_state_t        w_next_state;
  logic [3:0]       r_wait_cnt;
  logic             r_tx_start;
  logic [7:0]       r_tx_data;

  logic w_hdr_ok;
  logic w_dir_ok;
  logic w_accept;
  logic w_reject;
  logic w_wd_expired;
  logic w_per_wrap;
  logic w_issue;

  // Byte classification and counter terminal conditions.
  assign w_hdr_ok     = (rx_data[7:6] == 2'b10);
  assign w_dir_ok     = !(rx_data[0] && rx_data[1]);
  assign w_accept     = rx_valid && w_hdr_ok && w_dir_ok;
  assign w_reject     = rx_valid && !(w_hdr_ok && w_dir_ok);
  assign w_wd_expired = (r_wd_cnt == WD_LAST);
  assign w_per_wrap   = (r_per_cnt == PER_LAST);

  // Command register, strobes, error counter and link-lost flag; an accept beats a watchdog expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd       <= 6'd0;
      r_cmd_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_count <= 8'd0;
      r_link_lost <= 1'b0;
    end else begin
      r_cmd_valid <= w_accept;
      r_frame_err <= w_reject;
      if (w_accept) begin
        r_cmd       <= rx_data[5:0];
        r_link_lost <= 1'b0;
      end else if (w_wd_expired) begin
        r_cmd       <= 6'd0;
        r_link_lost <= 1'b1;
      end else begin
        r_cmd       <= r_cmd;
        r_link_lost <= r_link_lost;
      end
      if (w_reject && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end else begin
        r_err_count <= r_err_count;
      end
    end
  end

  // Link watchdog: counts idle cycles and parks at the terminal value until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt <= CNT_ZERO;
    end else if (w_accept) begin
      r_wd_cnt <= CNT_ZERO;
    end else if (!w_wd_expired) begin
      r_wd_cnt <= r_wd_cnt + CNT_ONE;
    end else begin
      r_wd_cnt <= r_wd_cnt;
    end
  end

  // Unsolicited reply period counter, restarted by every accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_per_cnt <= CNT_ZERO;
    end else if (w_accept || w_per_wrap) begin
      r_per_cnt <= CNT_ZERO;
    end else begin
      r_per_cnt <= r_per_cnt + CNT_ONE;
    end
  end

  // Single reply-pending flag; new requests coalesce and survive the cycle that services the old one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
    end else begin
      r_pending <= w_accept || w_per_wrap || (r_pending && !w_issue);
    end
  end

  // Transmit FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Transmit FSM next state: handshake on tx_busy, give up waiting for it after 16 cycles.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_pending && !tx_busy) w_next_state = ST_WAIT_HI;
        else                       w_next_state = ST_IDLE;
      end
      ST_WAIT_HI: begin
        if (tx_busy)                       w_next_state = ST_WAIT_LO;
        else if (r_wait_cnt == HI_LAST)    w_next_state = ST_IDLE;
        else                               w_next_state = ST_WAIT_HI;
      end
      ST_WAIT_LO: begin
        if (!tx_busy) w_next_state = ST_IDLE;
        else          w_next_state = ST_WAIT_LO;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Transmit FSM outputs: decide when a reply is issued.
  always_comb begin
    w_issue = 1'b0;
    case (r_state)
      ST_IDLE:    w_issue = r_pending && !tx_busy;
      ST_WAIT_HI: w_issue = 1'b0;
      ST_WAIT_LO: w_issue = 1'b0;
      default:    w_issue = 1'b0;
    endcase
  end

  // Cycle counter for the WAIT_HI give-up timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= 4'd0;
    end else if (r_state == ST_WAIT_HI) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end else begin
      r_wait_cnt <= 4'd0;
    end
  end

  // Registered transmit request and status byte; the byte holds until the next request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'd0;
    end else begin
      r_tx_start <= w_issue;
      if (w_issue) begin
        r_tx_data <= {4'b0000, back_in, right_in, left_in, front_in};
      end else begin
        r_tx_data <= r_tx_data;
      end
    end
  end

  assign tx_start        = r_tx_start;
  assign tx_data         = r_tx_data;
  assign move_forward    = r_cmd[0];
  assign move_backward   = r_cmd[1];
  assign turn_left       = r_cmd[2];
  assign turn_right      = r_cmd[3];
  assign place_barrier   = r_cmd[4];
  assign destroy_barrier = r_cmd[5];
  assign cmd_valid       = r_cmd_valid;
  assign frame_err       = r_frame_err;
  assign err_count       = r_err_count;
  assign link_lost       = r_link_lost;

endmodule

// File: tb/tb_car_link_responder.sv
// Self-checking bench for car_link_responder: scoreboard queues for command
// and error strobes, a monitor for replies, and a simple UART busy model.
module tb_car_link_responder;

  localparam int TO = 100;
  localparam int RP = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       front_in = 1'b0, left_in = 1'b0, right_in = 1'b0, back_in = 1'b0;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       move_forward, move_backward, turn_left, turn_right;
  logic       place_barrier, destroy_barrier;
  logic       cmd_valid, frame_err, link_lost;
  logic [7:0] err_count;

  car_link_responder #(.TIMEOUT_CYCLES(TO), .REPLY_PERIOD(RP), .CNT_W(26)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_busy(tx_busy), .front_in(front_in), .left_in(left_in),
    .right_in(right_in), .back_in(back_in), .tx_data(tx_data),
    .tx_start(tx_start), .move_forward(move_forward),
    .move_backward(move_backward), .turn_left(turn_left),
    .turn_right(turn_right), .place_barrier(place_barrier),
    .destroy_barrier(destroy_barrier), .cmd_valid(cmd_valid),
    .frame_err(frame_err), .err_count(err_count), .link_lost(link_lost)
  );

  always #5 clk = ~clk;

  logic [5:0] cmd_out;
  assign cmd_out = {destroy_barrier, place_barrier, turn_right, turn_left, move_backward, move_forward};

  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [3:0] sens_at_edge = 4'd0;
  bit         mon_en = 1'b0;
  int         tx_count = 0;
  int         last_tx_cyc = -1000;
  logic [7:0] last_tx_data = 8'h00;
  int         tx_times[$];
  logic [5:0] q_cmd[$];
  logic [7:0] q_err[$];
  int         m_err = 0;
  logic [5:0] m_cmd = 6'd0;
  bit         force_busy = 1'b0;
  int         busy_len = 10;
  int         busy_left = 0;

  assign tx_busy = force_busy || (busy_left != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  // cycle counter and sensor value seen by the DUT at each edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    sens_at_edge <= {back_in, right_in, left_in, front_in};
  end

  // UART transmitter model: busy for busy_len cycles after each request
  always @(negedge clk) begin
    if (mon_en && tx_start && busy_len > 0) busy_left <= busy_len;
    else if (busy_left > 0) busy_left <= busy_left - 1;
  end

  // monitor: pops scoreboard entries on each DUT strobe
  always @(negedge clk) begin
    if (mon_en) begin
      if (cmd_valid) begin
        if (q_cmd.size() == 0) fail_now("cmd_valid_unexpected");
        else begin
          logic [5:0] e;
          e = q_cmd.pop_front();
          check("cmd_bits", cmd_out, e);
          check("cmd_link_lost", link_lost, 0);
        end
      end
      if (frame_err) begin
        if (q_err.size() == 0) fail_now("frame_err_unexpected");
        else begin
          logic [7:0] e;
          e = q_err.pop_front();
          check("err_count", err_count, e);
        end
      end
      if (tx_start) begin
        check("tx_data_sensors", tx_data, {4'b0000, sens_at_edge});
        tx_count++;
        last_tx_cyc = cyc;
        last_tx_data = tx_data;
        tx_times.push_back(cyc);
      end
    end
  end

  function automatic logic [7:0] gen_good();
    logic [7:0] b;
    b = {2'b10, 6'($urandom_range(0, 63))};
    if (b[1:0] == 2'b11) b[1] = 1'b0;
    return b;
  endfunction

  function automatic logic [7:0] gen_bad();
    int v;
    do v = $urandom_range(0, 255); while ((v / 64 == 2) && (v % 4 != 3));
    return 8'(v);
  endfunction

  // one-cycle rx strobe; expectation pushed at issue time
  task automatic send_byte(input logic [7:0] b);
    int v;
    v = b;
    rx_data = b;
    rx_valid = 1'b1;
    if ((v / 64 == 2) && (v % 4 != 3)) begin
      q_cmd.push_back(b[5:0]);
      m_cmd = b[5:0];
    end else begin
      if (m_err < 255) m_err++;
      q_err.push_back(8'(m_err));
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic wait_quiet();
    int k;
    k = 0;
    while (((cyc - last_tx_cyc) < 20 || busy_left != 0) && k < 600) begin
      @(negedge clk);
      k++;
    end
    if (k >= 600) fail_now("quiet_timeout");
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    repeat (3) @(negedge clk);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_cmds", cmd_out, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_err_count", err_count, 0);
    check("rst_link_lost", link_lost, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // first command and its reply
    front_in = 1'b1; left_in = 1'b1;
    @(negedge clk);
    n0 = tx_count;
    send_byte(8'hA1);
    check("a1_destroy", destroy_barrier, 1);
    check("a1_forward", move_forward, 1);
    repeat (10) @(negedge clk);
    check("a1_tx_count", tx_count - n0, 1);
    check("a1_tx_data", last_tx_data, 8'h03);

    // rejected bytes
    n0 = tx_count;
    send_byte(8'h41);
    send_byte(8'h83);
    repeat (30) @(negedge clk);
    check("bad_err_count", err_count, 2);
    check("bad_cmds_kept", cmd_out, m_cmd);
    check("bad_no_reply", tx_count - n0, 0);

    // watchdog expiry boundary
    send_byte(8'h81);
    repeat (99) @(negedge clk);
    check("wd_before_lost", link_lost, 0);
    check("wd_before_cmds", cmd_out, 6'h01);
    @(negedge clk);
    check("wd_lost", link_lost, 1);
    check("wd_cmds_cleared", cmd_out, 6'h00);
    send_byte(8'h84);
    check("wd_turn_left", turn_left, 1);
    check("wd_relink", link_lost, 0);
    m_cmd = 6'h04;
    repeat (99) @(negedge clk);
    send_byte(8'h88);
    check("wd_race_cmds", cmd_out, 6'h08);
    check("wd_race_link", link_lost, 0);
    @(negedge clk);
    check("wd_race_link2", link_lost, 0);

    // periodic replies
    front_in = 1'b0; left_in = 1'b0; back_in = 1'b1; right_in = 1'b1;
    @(negedge clk);
    tx_times.delete();
    repeat (1000) @(negedge clk);
    check("per_count_ge4", tx_times.size() >= 4, 1);
    for (int i = 1; i < tx_times.size(); i++)
      check("per_interval", tx_times[i] - tx_times[i-1], RP);
    check("per_tx_data", last_tx_data, 8'h0C);

    // transmitter held busy while commands arrive
    wait_quiet();
    force_busy = 1'b1;
    n0 = tx_count;
    for (int i = 0; i < 3; i++) begin
      repeat (50) @(negedge clk);
      send_byte(gen_good());
    end
    repeat (49) @(negedge clk);
    check("hold_no_tx", tx_count - n0, 0);
    force_busy = 1'b0;
    @(negedge clk);
    check("hold_tx_after_fall", tx_start, 1);
    repeat (30) @(negedge clk);
    check("hold_one_tx", tx_count - n0, 1);

    // transmitter never acknowledges
    wait_quiet();
    busy_len = 0;
    tx_times.delete();
    send_byte(gen_good());
    repeat (4) @(negedge clk);
    send_byte(gen_good());
    repeat (40) @(negedge clk);
    check("nobusy_tx_count", tx_times.size(), 2);
    if (tx_times.size() == 2) check("nobusy_interval", tx_times[1] - tx_times[0], 17);
    busy_len = 10;

    // randomized mix of good and bad bytes
    for (int i = 0; i < 60; i++) begin
      send_byte(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    check("mix_cmds", cmd_out, m_cmd);

    // error counter saturation
    for (int i = 0; i < 300; i++) send_byte(gen_bad());
    repeat (5) @(negedge clk);
    check("sat_err_count", err_count, 8'd255);
    check("sb_cmd_empty", q_cmd.size(), 0);
    check("sb_err_empty", q_err.size(), 0);

    // asynchronous reset mid-run
    mon_en = 1'b0;
    check("pre_rst_tx_data", tx_data, 8'h0C);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tx_data", tx_data, 0);
    check("async_rst_tx_start", tx_start, 0);
    check("async_rst_err", err_count, 0);
    check("async_rst_cmds", cmd_out, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
